// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch (IF)
// port and the data-memory (DM) port of the pipeline. Only one access is in
// flight at a time. Each port sees a stall while its request is outstanding
// and a one-cycle valid pulse when the access completes.
//
// DM has priority. IF is forced through after STARVE_LIM consecutive DM grants
// made while IF was waiting. An access that gets no mem_ack within TIMEOUT
// BUSY cycles is aborted. It then completes with rdata = 0 and an err pulse.
//
// Ports
//   clk_i, rst_ni        system clock (rising edge), async active-low reset
//   if_req_i, if_addr_i  fetch request/address, held until if_valid_o
//   if_rdata_o           fetched word, valid with if_valid_o
//   if_valid_o           one-cycle completion pulse for IF
//   if_stall_o           if_req_i & ~if_valid_o
//   dm_req_i, dm_we_i    data request / write enable, held until dm_valid_o
//   dm_addr_i            data address
//   dm_wdata_i           write data
//   dm_wstrb_i           write byte enables
//   dm_rdata_o           read data, valid with dm_valid_o
//   dm_valid_o           one-cycle completion pulse for DM
//   dm_stall_o           dm_req_i & ~dm_valid_o
//   mem_req_o            registered memory request
//   mem_we_o             registered write enable
//   mem_addr_o           registered address
//   mem_wdata_o          registered write data
//   mem_wstrb_o          registered byte enables (zero for reads)
//   mem_rdata_i          memory read data, valid with mem_ack_i
//   mem_ack_i            memory completion
//   err_o                pulses with the valid of a timed-out access
//
// State table
//   state | meaning
//   IDLE  | no access in flight; grant to a waiting requester at the next edge
//   BUSY  | mem_* driven and held; waiting for mem_ack_i or timeout
//   RESP  | one cycle; owner's valid (and err on timeout) asserted, no grant
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [DATA_W-1:0]     if_rdata_o,
  output logic                  if_valid_o,
  output logic                  if_stall_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_W-1:0]     dm_addr_i,
  input  logic [DATA_W-1:0]     dm_wdata_i,
  input  logic [DATA_W/8-1:0]   dm_wstrb_i,
  output logic [DATA_W-1:0]     dm_rdata_o,
  output logic                  dm_valid_o,
  output logic                  dm_stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_wstrb_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  err_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned STV_W  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  // Timeout is a down-counter loaded at grant; reaching zero in BUSY without
  // an ack ends the TIMEOUT-th BUSY cycle.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  state_e              state_q,     state_d;
  owner_e              owner_q,     owner_d;
  logic [TMO_W-1:0]    tmo_q,       tmo_d;
  logic [STV_W-1:0]    starve_q,    starve_d;
  logic                tmo_hit_q,   tmo_hit_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;

  logic                grant_if;

  // IF only beats a pending DM request once it has been passed over
  // STARVE_LIM times in a row.
  assign grant_if = if_req_i && (!dm_req_i || (starve_q == STV_MAX));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    tmo_d       = tmo_q;
    starve_d    = starve_q;
    tmo_hit_d   = tmo_hit_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!if_req_i) begin
          starve_d = '0;
        end
        if (if_req_i || dm_req_i) begin
          state_d   = ST_BUSY;
          mem_req_d = 1'b1;
          tmo_d     = TMO_LOAD;
          tmo_hit_d = 1'b0;
          if (grant_if) begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_DM;
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            mem_wstrb_d = dm_we_i ? dm_wstrb_i : '0;
            if (if_req_i && (starve_q != STV_MAX)) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end

      ST_BUSY: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata_i;
          end else begin
            dm_rdata_d = mem_rdata_i;
          end
        end else if (tmo_q == '0) begin
          mem_req_d = 1'b0;
          tmo_hit_d = 1'b1;
          state_d   = ST_RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = '0;
          end else begin
            dm_rdata_d = '0;
          end
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      tmo_q       <= '0;
      starve_q    <= '0;
      tmo_hit_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      tmo_q       <= tmo_d;
      starve_q    <= starve_d;
      tmo_hit_q   <= tmo_hit_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Valid and err are decoded from registered state, so an async reset
  // removes them at once together with mem_req.
  assign if_valid_o  = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign dm_valid_o  = (state_q == ST_RESP) && (owner_q == OWN_DM);
  assign err_o       = (state_q == ST_RESP) && tmo_hit_q;

  assign if_stall_o  = if_req_i & ~if_valid_o;
  assign dm_stall_o  = dm_req_i & ~dm_valid_o;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        if_stall_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_wstrb_i;
  logic [31:0] dm_rdata_o;
  logic        dm_valid_o;
  logic        dm_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        err_o;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIM(4), .TIMEOUT(64)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_wstrb_i(dm_wstrb_i), .dm_rdata_o(dm_rdata_o),
    .dm_valid_o(dm_valid_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        x_req;
    logic        x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [3:0]  x_wstrb;
    logic        x_ifv;
    logic        x_dmv;
    logic [31:0] x_ifrd;
    logic [31:0] x_dmrd;
    logic        x_err;
    logic        x_ifs;
    logic        x_dms;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_req;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_row(input int idx, input vec_t v);
    logic ok;
    ok = (mem_req_o === v.x_req) && (if_valid_o === v.x_ifv) && (dm_valid_o === v.x_dmv) &&
         (if_rdata_o === v.x_ifrd) && (dm_rdata_o === v.x_dmrd) && (err_o === v.x_err) &&
         (if_stall_o === v.x_ifs) && (dm_stall_o === v.x_dms);
    // Memory-side fields only matter while a request is outstanding.
    if (v.x_req)
      ok = ok && (mem_we_o === v.x_we) && (mem_addr_o === v.x_addr) &&
           (mem_wdata_o === v.x_wdata) && (mem_wstrb_o === v.x_wstrb);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL vec%0d got req=%b we=%b addr=%h wd=%h ws=%h ifv=%b dmv=%b ifrd=%h dmrd=%h err=%b ifs=%b dms=%b required req=%b we=%b addr=%h wd=%h ws=%h ifv=%b dmv=%b ifrd=%h dmrd=%h err=%b ifs=%b dms=%b",
               idx, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, if_valid_o, dm_valid_o,
               if_rdata_o, dm_rdata_o, err_o, if_stall_o, dm_stall_o,
               v.x_req, v.x_we, v.x_addr, v.x_wdata, v.x_wstrb, v.x_ifv, v.x_dmv,
               v.x_ifrd, v.x_dmrd, v.x_err, v.x_ifs, v.x_dms);
    end
  endtask

  // Memory model: ack arrives in the cycle after mem_req is first seen high.
  task automatic tick(output logic rose);
    @(negedge clk_i);
    rose      = mem_req_o && !prev_req;
    mem_ack_i = mem_req_o && prev_req;
    prev_req  = mem_req_o;
  endtask

  initial begin
    logic        rose;
    logic [31:0] gaddr [10];
    logic [31:0] gexp  [10];
    int          ngr, overlap, busy, ifv_cnt, dmv_cnt;
    logic        done;
    logic [31:0] got_addr;

    rst_ni = 1'b0; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_addr_i = '0; dm_wdata_i = '0; dm_wstrb_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
    prev_req = 1'b0;

    // IF read, ack one cycle after mem_req, ack outside BUSY ignored
    vecs.push_back(vec_t'{1'b1,32'h40,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,32'h0,        1'b1,1'b0,32'h40,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,1'b0,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,32'h40,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,32'h0,        1'b1,1'b0,32'h40,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,1'b0,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,32'h40,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,32'h00500093, 1'b0,1'b0,32'h0,32'h0,4'h0,  1'b1,1'b0,32'h00500093,32'h0,1'b0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,32'hFFFFFFFF,  1'b0,1'b0,32'h0,32'h0,4'h0,  1'b0,1'b0,32'h00500093,32'h0,1'b0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,32'hFFFFFFFF,  1'b0,1'b0,32'h0,32'h0,4'h0,  1'b0,1'b0,32'h00500093,32'h0,1'b0,1'b0,1'b0});
    // IF and DM together: DM first, then IF
    vecs.push_back(vec_t'{1'b1,32'h44,1'b1,1'b0,32'h100,32'h0,4'h0,1'b0,32'h0,      1'b1,1'b0,32'h100,32'h0,4'h0, 1'b0,1'b0,32'h00500093,32'h0,1'b0,1'b1,1'b1});
    vecs.push_back(vec_t'{1'b1,32'h44,1'b1,1'b0,32'h100,32'h0,4'h0,1'b0,32'h0,      1'b1,1'b0,32'h100,32'h0,4'h0, 1'b0,1'b0,32'h00500093,32'h0,1'b0,1'b1,1'b1});
    vecs.push_back(vec_t'{1'b1,32'h44,1'b1,1'b0,32'h100,32'h0,4'h0,1'b1,32'h11112222, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h00500093,32'h11112222,1'b0,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,32'h44,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,4'h0,  1'b0,1'b0,32'h00500093,32'h11112222,1'b0,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,32'h44,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,32'h0,        1'b1,1'b0,32'h44,32'h0,4'h0, 1'b0,1'b0,32'h00500093,32'h11112222,1'b0,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,32'h44,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,32'h0,        1'b1,1'b0,32'h44,32'h0,4'h0, 1'b0,1'b0,32'h00500093,32'h11112222,1'b0,1'b1,1'b0});
    vecs.push_back(vec_t'{1'b1,32'h44,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,32'h33334444, 1'b0,1'b0,32'h0,32'h0,4'h0,  1'b1,1'b0,32'h33334444,32'h11112222,1'b0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,32'h0,         1'b0,1'b0,32'h0,32'h0,4'h0,  1'b0,1'b0,32'h33334444,32'h11112222,1'b0,1'b0,1'b0});
    // DM write, mem_we/mem_wstrb stable through BUSY
    vecs.push_back(vec_t'{1'b0,32'h0,1'b1,1'b1,32'h20,32'hDEADBEEF,4'h3,1'b0,32'h0, 1'b1,1'b1,32'h20,32'hDEADBEEF,4'h3, 1'b0,1'b0,32'h33334444,32'h11112222,1'b0,1'b0,1'b1});
    vecs.push_back(vec_t'{1'b0,32'h0,1'b1,1'b1,32'h20,32'hDEADBEEF,4'h3,1'b0,32'h0, 1'b1,1'b1,32'h20,32'hDEADBEEF,4'h3, 1'b0,1'b0,32'h33334444,32'h11112222,1'b0,1'b0,1'b1});
    vecs.push_back(vec_t'{1'b0,32'h0,1'b1,1'b1,32'h20,32'hDEADBEEF,4'h3,1'b0,32'h0, 1'b1,1'b1,32'h20,32'hDEADBEEF,4'h3, 1'b0,1'b0,32'h33334444,32'h11112222,1'b0,1'b0,1'b1});
    vecs.push_back(vec_t'{1'b0,32'h0,1'b1,1'b1,32'h20,32'hDEADBEEF,4'h3,1'b1,32'hCAFEF00D, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h33334444,32'hCAFEF00D,1'b0,1'b0,1'b0});
    vecs.push_back(vec_t'{1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,32'h0,         1'b0,1'b0,32'h0,32'h0,4'h0,  1'b0,1'b0,32'h33334444,32'hCAFEF00D,1'b0,1'b0,1'b0});

    // Reset state
    repeat (2) @(negedge clk_i);
    check("reset_ctl", {57'd0, mem_req_o, mem_we_o, if_valid_o, dm_valid_o, err_o, if_stall_o, dm_stall_o}, 64'd0);
    check("reset_addr_wd", {mem_addr_o, mem_wdata_o}, 64'd0);
    check("reset_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);
    check("reset_wstrb", {60'd0, mem_wstrb_o}, 64'd0);
    rst_ni = 1'b1;

    // Table-driven vectors: drive at negedge, compare at following negedge
    for (int i = 0; i < vecs.size(); i++) begin
      if_req_i = vecs[i].if_req;  if_addr_i = vecs[i].if_addr;
      dm_req_i = vecs[i].dm_req;  dm_we_i = vecs[i].dm_we;  dm_addr_i = vecs[i].dm_addr;
      dm_wdata_i = vecs[i].dm_wdata; dm_wstrb_i = vecs[i].dm_wstrb;
      mem_ack_i = vecs[i].mem_ack; mem_rdata_i = vecs[i].mem_rdata;
      @(negedge clk_i);
      check_row(i, vecs[i]);
    end

    // Starvation guard: both requesters held continuously
    if_req_i = 1'b1; if_addr_i = 32'h400;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h800; dm_wdata_i = '0; dm_wstrb_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h12345678; prev_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      gaddr[k] = '0;
      gexp[k]  = (k == 4 || k == 9) ? 32'h400 : 32'h800;
    end
    ngr = 0; overlap = 0;
    for (int c = 0; c < 300 && ngr < 10; c++) begin
      tick(rose);
      if (if_valid_o && dm_valid_o) overlap++;
      if (rose) begin gaddr[ngr] = mem_addr_o; ngr++; end
    end
    check("starve_grant_count", 64'(ngr), 64'd10);
    for (int k = 0; k < 10; k++) check($sformatf("starve_grant%0d", k), {32'd0, gaddr[k]}, {32'd0, gexp[k]});
    // IF owns the last access; dropping its request must not cancel it
    if_req_i = 1'b0; dm_req_i = 1'b0; ifv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick(rose);
      if (if_valid_o && dm_valid_o) overlap++;
      if (if_valid_o) ifv_cnt++;
    end
    check("starve_valid_overlap", 64'(overlap), 64'd0);
    check("drop_req_valid", 64'(ifv_cnt), 64'd1);
    check("starve_dm_rdata", {32'd0, dm_rdata_o}, {32'd0, 32'h12345678});

    // Timeout: memory never acks
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    mem_ack_i = 1'b0; mem_rdata_i = 32'hA5A5A5A5;
    busy = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      if (mem_req_o) busy++;
      else if (busy > 0) done = 1'b1;
    end
    check("tmo_done", {63'd0, done}, 64'd1);
    check("tmo_busy_cycles", 64'(busy), 64'd64);
    check("tmo_valid_err", {60'd0, dm_valid_o, err_o, if_valid_o, mem_req_o}, {60'd0, 4'b1100});
    check("tmo_rdata_zero", {32'd0, dm_rdata_o}, 64'd0);
    dm_req_i = 1'b0;
    @(negedge clk_i);
    check("tmo_err_pulse", {62'd0, err_o, dm_valid_o}, 64'd0);

    // Normal IF access after a timeout
    if_req_i = 1'b1; if_addr_i = 32'h500; mem_rdata_i = 32'h0BADF00D;
    prev_req = mem_req_o; done = 1'b0; got_addr = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick(rose);
      if (rose) got_addr = mem_addr_o;
      if (if_valid_o) done = 1'b1;
    end
    check("post_tmo_valid", {63'd0, done}, 64'd1);
    check("post_tmo_addr", {32'd0, got_addr}, {32'd0, 32'h500});
    check("post_tmo_rdata_err", {31'd0, if_rdata_o, err_o}, {31'd0, 32'h0BADF00D, 1'b0});
    if_req_i = 1'b0;
    tick(rose);

    // Reset in the middle of BUSY
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300; mem_ack_i = 1'b0;
    mem_rdata_i = 32'h77778888;
    @(negedge clk_i);
    check("rst_pre_grant", {63'd0, mem_req_o}, 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async_ctl", {60'd0, mem_req_o, if_valid_o, dm_valid_o, err_o}, 64'd0);
    check("rst_async_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);
    @(negedge clk_i);
    check("rst_held", {63'd0, mem_req_o}, 64'd0);
    rst_ni = 1'b1;
    prev_req = 1'b0; got_addr = '0; dmv_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick(rose);
      if (rose) got_addr = mem_addr_o;
      if (dm_valid_o) begin
        dmv_cnt++;
        check("rst_regrant_rdata", {32'd0, dm_rdata_o}, {32'd0, 32'h77778888});
        dm_req_i = 1'b0;
      end
    end
    check("rst_regrant_addr", {32'd0, got_addr}, {32'd0, 32'h300});
    check("rst_regrant_valids", 64'(dmv_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
